// File: rtl/commit_unit_pkg.sv
`default_nettype none
// ============================================================================
// commit_unit_pkg : reorder-buffer entry layout, unit/state encodings, tag helpers
// Revision 1.0
// ============================================================================
package commit_unit_pkg;

    localparam int BUF_SIZE_LOG = 4;
    localparam int BUF_SIZE     = 2 ** BUF_SIZE_LOG;
    localparam int TAG_W        = BUF_SIZE_LOG + 1;

    typedef enum logic [1:0] {
        S_NOT_USED  = 2'd0,
        S_WAITING   = 2'd1,
        S_EXECUTING = 2'd2,
        S_EXECUTED  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        U_ALU    = 2'd0,
        U_BRANCH = 2'd1,
        U_LOAD   = 2'd2,
        U_STORE  = 2'd3
    } unit_t;

    typedef enum logic [2:0] {
        LS_B  = 3'b000,
        LS_H  = 3'b001,
        LS_W  = 3'b010,
        LS_BU = 3'b100,
        LS_HU = 3'b101
    } ldst_mode_t;

    typedef enum logic [0:0] {
        RUN        = 1'b0,
        STORE_WAIT = 1'b1
    } fsm_t;

    typedef struct packed {
        state_t           e_state;
        unit_t            unit;
        logic             link;
        logic [TAG_W-1:0] tag;
        logic [4:0]       dest;
        logic [31:0]      result;
        logic [31:0]      a;
        logic [31:0]      vk;
        ldst_mode_t       rwmm;
    } entry_t;

    // Tag 0 is reserved, so the sequence wraps from all-ones back to 1.
    function automatic logic [TAG_W-1:0] tag_inc(input logic [TAG_W-1:0] t);
        return (t == {TAG_W{1'b1}}) ? TAG_W'(1) : t + TAG_W'(1);
    endfunction

    // Branches only write the register file when they carry a link.
    function automatic logic writes_rf(input entry_t e);
        return (e.unit != U_STORE) && !((e.unit == U_BRANCH) && !e.link) && (e.dest != 5'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/commit_unit_tag_finder.sv
`default_nettype none
// ============================================================================
// tag_finder : associative tag lookup, lowest matching index wins
// Revision 1.0
// ============================================================================
module tag_finder #(
    parameter int N     = 16,
    parameter int TAG_W = 5
) (
    input  logic [TAG_W-1:0]          i_tag,
    input  logic [N-1:0][TAG_W-1:0]   i_tags,
    input  logic [N-1:0]              i_valid,
    output logic                      o_hit,
    output logic [$clog2(N)-1:0]      o_idx
);

    localparam int IDX_W = $clog2(N);

    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        // Scan downwards so the last (lowest) match overrides higher ones.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_valid[i] && (i_tags[i] == i_tag)) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/commit_unit.sv
`default_nettype none
// ============================================================================
// commit_unit : in-order two-wide retirement from the reorder buffer
// Revision 1.0
// ============================================================================
module commit_unit
    import commit_unit_pkg::*;
#(
    // Entry layout is fixed by the package; keep this equal to its BUF_SIZE_LOG.
    parameter int BUF_SIZE_LOG = commit_unit_pkg::BUF_SIZE_LOG
) (
    input  logic                        clk,
    input  logic                        reset,
    input  entry_t                      entries [2**BUF_SIZE_LOG],
    input  logic                        dmem_ready,
    output logic [1:0]                  is_really_commited,
    output logic [1:0]                  is_commited_store,
    output logic [1:0][BUF_SIZE_LOG:0]  commited_tags,
    output logic [1:0]                  rf_we,
    output logic [1:0][4:0]             rf_addr,
    output logic [1:0][31:0]            rf_data,
    output logic                        dmem_we,
    output logic [31:0]                 dmem_addr,
    output logic [31:0]                 dmem_wdata,
    output logic [2:0]                  dmem_mode,
    output logic [31:0]                 commit_count
);

    localparam int N_ENTRIES = 2 ** BUF_SIZE_LOG;

    fsm_t                            r_state;
    fsm_t                            w_state_nxt;
    logic [TAG_W-1:0]                r_head;
    logic [TAG_W-1:0]                w_head_p1;
    logic [31:0]                     r_count;

    logic [N_ENTRIES-1:0][TAG_W-1:0] w_tags;
    logic [N_ENTRIES-1:0]            w_used;
    logic                            w_hit0;
    logic                            w_hit1;
    logic [BUF_SIZE_LOG-1:0]         w_idx0;
    logic [BUF_SIZE_LOG-1:0]         w_idx1;
    entry_t                          w_e0;
    entry_t                          w_e1;
    logic                            w_s0_exec;
    logic                            w_s1_exec;
    logic                            w_s0_store;
    logic                            w_s1_store;
    logic                            w_c0;
    logic                            w_c1;

    generate
        for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_unpack
            assign w_tags[gi] = entries[gi].tag;
            assign w_used[gi] = (entries[gi].e_state != S_NOT_USED);
        end
    endgenerate

    assign w_head_p1 = tag_inc(r_head);

    tag_finder #(.N(N_ENTRIES), .TAG_W(TAG_W)) u_find_slot0 (
        .i_tag   (r_head),
        .i_tags  (w_tags),
        .i_valid (w_used),
        .o_hit   (w_hit0),
        .o_idx   (w_idx0)
    );

    tag_finder #(.N(N_ENTRIES), .TAG_W(TAG_W)) u_find_slot1 (
        .i_tag   (w_head_p1),
        .i_tags  (w_tags),
        .i_valid ({N_ENTRIES{1'b1}}),
        .o_hit   (w_hit1),
        .o_idx   (w_idx1)
    );

    assign w_e0       = entries[w_idx0];
    assign w_e1       = entries[w_idx1];
    assign w_s0_exec  = w_hit0 && (w_e0.e_state == S_EXECUTED);
    assign w_s1_exec  = w_hit1 && (w_e1.e_state == S_EXECUTED);
    assign w_s0_store = (w_e0.unit == U_STORE);
    assign w_s1_store = (w_e1.unit == U_STORE);

    always_comb begin
        w_state_nxt = r_state;
        w_c0        = 1'b0;
        w_c1        = 1'b0;
        case (r_state)
            RUN: begin
                if (w_s0_exec) begin
                    if (w_s0_store && !dmem_ready) begin
                        w_state_nxt = STORE_WAIT;
                    end else begin
                        w_c0 = 1'b1;
                    end
                end
                // Only one store per cycle, and only while memory is accepting.
                if (w_c0 && w_s1_exec && !(w_s1_store && (w_s0_store || !dmem_ready))) begin
                    w_c1 = 1'b1;
                end
            end
            STORE_WAIT: begin
                if (!(w_s0_exec && w_s0_store)) begin
                    w_state_nxt = RUN;
                end else if (dmem_ready) begin
                    w_c0        = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
        if (!reset) begin
            w_c0 = 1'b0;
            w_c1 = 1'b0;
        end
    end

    always_comb begin
        is_really_commited = {w_c1, w_c0};
        is_commited_store  = {w_c1 && w_s1_store, w_c0 && w_s0_store};
        commited_tags      = '0;
        rf_we              = '0;
        rf_addr            = '0;
        rf_data            = '0;
        dmem_we            = 1'b0;
        dmem_addr          = '0;
        dmem_wdata         = '0;
        dmem_mode          = '0;
        if (w_c0) begin
            commited_tags[0] = w_e0.tag;
            rf_we[0]         = writes_rf(w_e0);
            rf_addr[0]       = w_e0.dest;
            rf_data[0]       = w_e0.result;
        end
        if (w_c1) begin
            commited_tags[1] = w_e1.tag;
            rf_we[1]         = writes_rf(w_e1);
            rf_addr[1]       = w_e1.dest;
            rf_data[1]       = w_e1.result;
        end
        if (w_c0 && w_s0_store) begin
            dmem_we    = 1'b1;
            dmem_addr  = w_e0.a;
            dmem_wdata = w_e0.vk;
            dmem_mode  = w_e0.rwmm;
        end else if (w_c1 && w_s1_store) begin
            dmem_we    = 1'b1;
            dmem_addr  = w_e1.a;
            dmem_wdata = w_e1.vk;
            dmem_mode  = w_e1.rwmm;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_head  <= TAG_W'(1);
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_c1) begin
                r_head <= tag_inc(w_head_p1);
            end else if (w_c0) begin
                r_head <= w_head_p1;
            end
            r_count <= r_count + 32'(w_c0) + 32'(w_c1);
        end
    end

    assign commit_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_commit_unit.sv
`default_nettype none
// ============================================================================
// tb_commit_unit : directed stimulus with a queue-based scoreboard for commit_unit
// Revision 1.0
// ============================================================================
module tb_commit_unit;
    import commit_unit_pkg::*;

    typedef struct {
        logic [1:0]  commit;
        logic [1:0]  store;
        logic [1:0]  rfwe;
        logic [4:0]  t0;
        logic [4:0]  t1;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [2:0]  dmode;
        logic [31:0] cnt;
    } exp_t;

    logic            clk;
    logic            reset;
    entry_t          entries [16];
    logic            dmem_ready;
    logic [1:0]      is_really_commited;
    logic [1:0]      is_commited_store;
    logic [1:0][4:0] commited_tags;
    logic [1:0]      rf_we;
    logic [1:0][4:0] rf_addr;
    logic [1:0][31:0] rf_data;
    logic            dmem_we;
    logic [31:0]     dmem_addr;
    logic [31:0]     dmem_wdata;
    logic [2:0]      dmem_mode;
    logic [31:0]     commit_count;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    commit_unit #(.BUF_SIZE_LOG(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .entries            (entries),
        .dmem_ready         (dmem_ready),
        .is_really_commited (is_really_commited),
        .is_commited_store  (is_commited_store),
        .commited_tags      (commited_tags),
        .rf_we              (rf_we),
        .rf_addr            (rf_addr),
        .rf_data            (rf_data),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_mode          (dmem_mode),
        .commit_count       (commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("commit",     32'(is_really_commited), 32'(e.commit));
            chk("store",      32'(is_commited_store),  32'(e.store));
            chk("tag0",       32'(commited_tags[0]),   32'(e.t0));
            chk("tag1",       32'(commited_tags[1]),   32'(e.t1));
            chk("rf_we",      32'(rf_we),              32'(e.rfwe));
            chk("rf_addr0",   32'(rf_addr[0]),         32'(e.a0));
            chk("rf_addr1",   32'(rf_addr[1]),         32'(e.a1));
            chk("rf_data0",   rf_data[0],              e.d0);
            chk("rf_data1",   rf_data[1],              e.d1);
            chk("dmem_we",    32'(dmem_we),            32'(e.dwe));
            chk("dmem_addr",  dmem_addr,               e.daddr);
            chk("dmem_wdata", dmem_wdata,              e.dwdata);
            chk("dmem_mode",  32'(dmem_mode),          32'(e.dmode));
            chk("count",      commit_count,            e.cnt);
        end else if ((is_really_commited != 2'b00) || dmem_we) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit: got commit=%b dmem_we=%b expected none", is_really_commited, dmem_we);
        end
    end

    function automatic entry_t mk(input logic [4:0] tag, input state_t st, input unit_t u,
                                  input logic lnk, input logic [4:0] dest, input logic [31:0] res,
                                  input logic [31:0] a, input logic [31:0] vk, input ldst_mode_t m);
        entry_t e;
        e.e_state = st;
        e.unit    = u;
        e.link    = lnk;
        e.tag     = tag;
        e.dest    = dest;
        e.result  = res;
        e.a       = a;
        e.vk      = vk;
        e.rwmm    = m;
        return e;
    endfunction

    function automatic entry_t alu(input logic [4:0] tag, input logic [4:0] dest, input logic [31:0] res);
        return mk(tag, S_EXECUTED, U_ALU, 1'b0, dest, res, 32'h0, 32'h0, LS_W);
    endfunction

    function automatic entry_t st(input logic [4:0] tag, input logic [31:0] a, input logic [31:0] vk, input ldst_mode_t m);
        return mk(tag, S_EXECUTED, U_STORE, 1'b0, 5'd0, 32'h0, a, vk, m);
    endfunction

    function automatic exp_t idle(input logic [31:0] cnt);
        exp_t e;
        e = '{default: '0};
        e.cnt = cnt;
        return e;
    endfunction

    function automatic exp_t one(input logic [4:0] t, input logic [4:0] a, input logic [31:0] d,
                                 input logic we, input logic [31:0] cnt);
        exp_t e;
        e        = idle(cnt);
        e.commit = 2'b01;
        e.t0     = t;
        e.a0     = a;
        e.d0     = d;
        e.rfwe   = {1'b0, we};
        return e;
    endfunction

    function automatic exp_t two(input logic [4:0] t0, input logic [4:0] a0, input logic [31:0] d0, input logic we0,
                                 input logic [4:0] t1, input logic [4:0] a1, input logic [31:0] d1, input logic we1,
                                 input logic [31:0] cnt);
        exp_t e;
        e        = one(t0, a0, d0, we0, cnt);
        e.commit = 2'b11;
        e.t1     = t1;
        e.a1     = a1;
        e.d1     = d1;
        e.rfwe   = {we1, we0};
        return e;
    endfunction

    function automatic exp_t with_store(input exp_t base, input logic [1:0] mask, input logic [31:0] addr,
                                        input logic [31:0] data, input logic [2:0] mode);
        exp_t e;
        e        = base;
        e.store  = mask;
        e.dwe    = 1'b1;
        e.daddr  = addr;
        e.dwdata = data;
        e.dmode  = mode;
        return e;
    endfunction

    task automatic clr();
        for (int i = 0; i < 16; i++) entries[i] = '0;
    endtask

    // Inputs for this cycle are already driven; queue the expectation the monitor checks at negedge.
    task automatic step(input exp_t e);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        dmem_ready = 1'b0;
        clr();
        entries[0] = alu(5'd1, 5'd5, 32'h11);
        entries[1] = alu(5'd2, 5'd6, 32'h22);
        @(posedge clk);
        #1;
        step(idle(0));
        step(idle(0));

        // Dual ALU retire right after reset
        reset = 1'b1;
        step(two(5'd1, 5'd5, 32'h11, 1'b1, 5'd2, 5'd6, 32'h22, 1'b1, 0));
        clr();
        step(idle(2));

        // Slot 1 still executing, then retires as slot 0
        entries[3] = alu(5'd3, 5'd7, 32'h33);
        entries[4] = mk(5'd4, S_EXECUTING, U_ALU, 1'b0, 5'd8, 32'h44, 32'h0, 32'h0, LS_W);
        step(one(5'd3, 5'd7, 32'h33, 1'b1, 2));
        entries[3] = '0;
        entries[4] = alu(5'd4, 5'd8, 32'h44);
        step(one(5'd4, 5'd8, 32'h44, 1'b1, 3));

        // Register-write suppression: unlinked branch, dest 0; then linked branch and load
        clr();
        entries[6] = mk(5'd5, S_EXECUTED, U_BRANCH, 1'b0, 5'd9, 32'h55, 32'h0, 32'h0, LS_W);
        entries[1] = alu(5'd6, 5'd0, 32'h66);
        step(two(5'd5, 5'd9, 32'h55, 1'b0, 5'd6, 5'd0, 32'h66, 1'b0, 4));
        clr();
        entries[2] = mk(5'd7, S_EXECUTED, U_BRANCH, 1'b1, 5'd31, 32'h77, 32'h0, 32'h0, LS_W);
        entries[8] = mk(5'd8, S_EXECUTED, U_LOAD, 1'b0, 5'd3, 32'h88, 32'h0, 32'h0, LS_W);
        step(two(5'd7, 5'd31, 32'h77, 1'b1, 5'd8, 5'd3, 32'h88, 1'b1, 6));

        // Store stalls on memory, then drains
        clr();
        dmem_ready = 1'b0;
        entries[5] = st(5'd9, 32'h1000, 32'hDEADBEEF, LS_W);
        entries[0] = alu(5'd10, 5'd4, 32'hAA);
        repeat (3) step(idle(8));
        dmem_ready = 1'b1;
        step(with_store(one(5'd9, 5'd0, 32'h0, 1'b0, 8), 2'b01, 32'h1000, 32'hDEADBEEF, 3'b010));
        entries[5] = '0;
        step(one(5'd10, 5'd4, 32'hAA, 1'b1, 9));

        // Back-to-back stores retire one per cycle
        clr();
        entries[7] = st(5'd11, 32'h2000, 32'h1111, LS_B);
        entries[3] = st(5'd12, 32'h3000, 32'h2222, LS_H);
        step(with_store(one(5'd11, 5'd0, 32'h0, 1'b0, 10), 2'b01, 32'h2000, 32'h1111, 3'b000));
        entries[7] = '0;
        step(with_store(one(5'd12, 5'd0, 32'h0, 1'b0, 11), 2'b01, 32'h3000, 32'h2222, 3'b001));

        // Duplicate head tag (lowest index wins) with a store in slot 1
        clr();
        entries[2] = alu(5'd13, 5'd1, 32'hCC);
        entries[9] = alu(5'd13, 5'd2, 32'hDD);
        entries[5] = st(5'd14, 32'h4000, 32'h4444, LS_W);
        step(with_store(two(5'd13, 5'd1, 32'hCC, 1'b1, 5'd14, 5'd0, 32'h0, 1'b0, 12),
                        2'b10, 32'h4000, 32'h4444, 3'b010));

        // Walk head up to 31, then retire across the wrap
        for (int i = 0; i < 8; i++) begin
            clr();
            entries[i]      = alu(5'(15 + 2 * i), 5'(15 + 2 * i), 32'(15 + 2 * i));
            entries[15 - i] = alu(5'(16 + 2 * i), 5'(16 + 2 * i), 32'(16 + 2 * i));
            step(two(5'(15 + 2 * i), 5'(15 + 2 * i), 32'(15 + 2 * i), 1'b1,
                     5'(16 + 2 * i), 5'(16 + 2 * i), 32'(16 + 2 * i), 1'b1, 32'(14 + 2 * i)));
        end
        clr();
        entries[4] = alu(5'd31, 5'd2, 32'h31);
        entries[0] = alu(5'd1, 5'd3, 32'h01);
        step(two(5'd31, 5'd2, 32'h31, 1'b1, 5'd1, 5'd3, 32'h01, 1'b1, 30));
        clr();
        entries[10] = alu(5'd2, 5'd10, 32'h2);
        step(one(5'd2, 5'd10, 32'h2, 1'b1, 32));

        // Reset while a store is waiting aborts it
        clr();
        dmem_ready = 1'b0;
        entries[1] = st(5'd3, 32'h5000, 32'h5555, LS_W);
        step(idle(33));
        step(idle(33));
        reset      = 1'b0;
        dmem_ready = 1'b1;
        step(idle(0));
        reset = 1'b1;
        step(idle(0));
        clr();
        entries[6] = alu(5'd1, 5'd12, 32'h123);
        step(one(5'd1, 5'd12, 32'h123, 1'b1, 0));
        clr();
        step(idle(1));

        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/commit_unit.md
COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 SHALL have parameter BUF_SIZE_LOG, default 4, log2 of the buffer depth; BUF_SIZE = 2**BUF_SIZE_LOG.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have port entries  input  entry[BUF_SIZE]  current buffer contents.
REQ-005 SHALL have port dmem_ready  input  1  data memory accepts a write this cycle.
REQ-006 SHALL have port is_really_commited  output  1[2]  slot k committed this cycle.
REQ-007 SHALL have port is_commited_store  output  1[2]  committed slot k is a STORE.
REQ-008 SHALL have port commited_tags  output  BUF_SIZE_LOG+1[2]  tag of committed slot k.
REQ-009 SHALL have port rf_we  output  1[2]  register write enable per slot.
REQ-010 SHALL have port rf_addr  output  5[2]  destination register per slot.
REQ-011 SHALL have port rf_data  output  32[2]  write value (entry result) per slot.
REQ-012 SHALL have port dmem_we  output  1  store write strobe.
REQ-013 SHALL have port dmem_addr / dmem_wdata / dmem_mode  output  32/32/3  store address (A), data (Vk), ldst_mode (rwmm).
REQ-014 SHALL have port commit_count  output  32  retired-instruction counter.

Function
REQ-015 SHALL hold a head tag register (BUF_SIZE_LOG+1 bits) naming the oldest uncommitted tag; tag 0 is reserved and never committed.
REQ-016 Head increment SHALL wrap from 2**(BUF_SIZE_LOG+1)-1 to 1, skipping 0.
REQ-017 Slot 0 candidate: the entry with tag==head and e_state!=S_NOT_USED; slot 1 candidate: the entry with tag==head+1 (wrapped).
REQ-018 A slot SHALL commit only when its entry e_state==S_EXECUTED; slot 1 commits only if slot 0 commits in the same cycle.
REQ-019 At most one STORE SHALL commit per cycle; a STORE in slot 1 SHALL not commit when slot 0 is a STORE.
REQ-020 A STORE commits only when dmem_ready==1; dmem_we pulses for exactly that cycle with A, Vk, rwmm of the store.
REQ-021 FSM states: RUN, STORE_WAIT. RUN->STORE_WAIT when the slot-0 candidate is an executed STORE and dmem_ready==0; STORE_WAIT->RUN on the cycle dmem_ready==1 (store commits that cycle); no commits in STORE_WAIT other than that store.
REQ-022 rf_we[k] SHALL be 1 only for committed, non-STORE, non-BRANCH-without-link entries with Dest!=0.
REQ-023 Commit outputs SHALL be combinational from entries and current state (zero-cycle latency); head and commit_count SHALL update on the same edge by the number committed (0, 1, 2).
REQ-024 When no candidate matches head, all commit/write strobes SHALL be 0 and head SHALL hold.
REQ-025 commit_count SHALL wrap modulo 2**32.
REQ-026 Duplicate tag matches SHALL resolve to the lowest buffer index.

Reset
REQ-027 While reset==0: head=1, FSM=RUN, commit_count=0, all output strobes 0, data outputs 0.
REQ-028 Reset asserted mid-STORE_WAIT SHALL abort the store with no dmem_we pulse.

Structure
REQ-029 entry, state, unit, ldst_mode, BUF_SIZE_LOG and BUF_SIZE SHALL live in a shared package imported by the buffer and this block.
REQ-030 Tag lookup SHALL be a sub-module tag_finder (tag in -> hit, index out, lowest-index priority), instantiated twice.

Verification
REQ-031 After reset, tags 1 and 2 both S_EXECUTED ALU, Dest 5/6 -> one cycle with both slots committed, rf_we=2'b11, head=3, commit_count=2.
REQ-032 Tag 1 S_EXECUTED, tag 2 S_EXECUTING -> only slot 0 commits; next cycle, once tag 2 executes, it commits as slot 0.
REQ-033 Tag 1 STORE executed, dmem_ready=0 for 3 cycles -> STORE_WAIT, no commits; ready=1 -> dmem_we=1, A/Vk driven, is_commited_store[0]=1, head=2.
REQ-034 Tags 1 and 2 both executed STOREs, dmem_ready=1 -> only tag 1 commits this cycle; tag 2 commits the next.
REQ-035 Head=31 with tags 31 and 1 executed -> both commit, head becomes 2 (0 skipped).
REQ-036 Assert reset during STORE_WAIT -> no dmem_we, head=1, commit_count=0.
